vga_framebuffer: RTL and testbench

1-bpp, 640x480 frame buffer sitting directly upstream of the VGA timing/colour stage. The ARM SoC writes 32-pixel words through a valid/ready port. The display side takes the timing stage's pixel coordinates and returns the registered `pixel` bit that the timing stage drives onto red. An internal clear engine fills the whole buffer with a constant without CPU involvement.

---
 rtl/vga_framebuffer.sv | 180 ++++++++++++++++++
 tb/tb_vga_framebuffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_framebuffer.sv
// vga_framebuffer: 1-bpp 640x480 frame buffer with host write port, clear engine
// and a 2-cycle display read path. Optional DOUBLE_BUFFER_EN adds a swapped back bank.
module vga_framebuffer #(
    parameter int H_PIX = 640,
    parameter int V_PIX = 480
) (
    input  logic        CLOCK_50,
    input  logic        nReset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [13:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        clear_req,
    input  logic        clear_fill,
    output logic        busy,
    input  logic        pix_en,
    input  logic [9:0]  pixel_x,
    input  logic [8:0]  pixel_y,
    output logic        pixel,
    input  logic        VGA_VS,
`ifdef DOUBLE_BUFFER_EN
    input  logic        swap_req,
`endif
    output logic        swap_pending
);

    localparam int WORDS_PER_LINE = H_PIX / 32;
    localparam int DEPTH          = WORDS_PER_LINE * V_PIX;
`ifdef DOUBLE_BUFFER_EN
    localparam int BANKS          = 2;
`else
    localparam int BANKS          = 1;
`endif
    localparam int MEM_WORDS      = DEPTH * BANKS;
    localparam int IW             = $clog2(MEM_WORDS);

    localparam logic [13:0] DEPTH_W = 14'(DEPTH);
    localparam logic [13:0] LAST_W  = 14'(DEPTH - 1);
    localparam logic [13:0] WPL_W   = 14'(WORDS_PER_LINE);
    localparam logic [9:0]  H_LIM   = 10'(H_PIX);
    localparam logic [8:0]  V_LIM   = 9'(V_PIX);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [13:0] cnt;
    logic [13:0] cnt_d;
    logic        fill;
    logic        fill_d;

    logic        mem_we;
    logic [13:0] mem_wa;
    logic [31:0] mem_wd;
    logic [13:0] rd_addr;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] ram_q;
    logic [4:0]  bit_q;
    logic        qual_q;
    logic        qual;

    // ---------------- clear FSM ----------------
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            fill     <= 1'b0;
            wr_ready <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            fill     <= fill_d;
            wr_ready <= (state_d == S_IDLE);
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        fill_d  = fill;
        unique case (state)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    fill_d  = clear_fill;
                end
            end
            S_CLEAR: begin
                if (cnt == LAST_W)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt + 14'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state == S_CLEAR);

    // Clear engine owns the write port; host writes beyond the buffer are dropped.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wr_addr;
        mem_wd = wr_data;
        if (state == S_CLEAR) begin
            mem_we = 1'b1;
            mem_wa = cnt;
            mem_wd = {32{fill}};
        end else begin
            mem_we = wr_valid && wr_ready && (wr_addr < DEPTH_W);
        end
    end

    // Constant multiply reduces to (y<<4)+(y<<2) for the 20-word line.
    assign rd_addr = 14'(pixel_y) * WPL_W + 14'(pixel_x[9:5]);
    assign qual    = pix_en && (pixel_x < H_LIM) && (pixel_y < V_LIM);

`ifdef DOUBLE_BUFFER_EN
    localparam logic [IW-1:0] BANK1 = IW'(DEPTH);

    logic       front;
    logic [2:0] vs_sync;
    logic       vs_fall;

    assign vs_fall = vs_sync[2] && !vs_sync[1];
    assign wr_idx  = IW'(mem_wa) + (front ? '0 : BANK1);
    assign rd_idx  = IW'(rd_addr) + (front ? BANK1 : '0);

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            vs_sync      <= 3'b111;
            front        <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            vs_sync <= {vs_sync[1:0], VGA_VS};
            if (swap_pending && vs_fall) begin
                front        <= !front;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end
`else
    logic vga_vs_unused;

    assign vga_vs_unused = VGA_VS;
    assign swap_pending  = 1'b0;
    assign wr_idx        = IW'(mem_wa);
    assign rd_idx        = IW'(rd_addr);
`endif

    // ---------------- memory ----------------
    // Read-before-write: the read samples the array before the write lands.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we)
            mem[wr_idx] <= mem_wd;
        ram_q <= mem[rd_idx];
    end

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            bit_q  <= '0;
            qual_q <= 1'b0;
            pixel  <= 1'b0;
        end else begin
            bit_q  <= pixel_x[4:0];
            qual_q <= qual;
            pixel  <= ram_q[bit_q] && qual_q;
        end
    end

endmodule

// File: tb/tb_vga_framebuffer.sv
// tb_vga_framebuffer: directed checks of write, read, clear and reset paths;
// the bank swap sequence runs instead when DOUBLE_BUFFER_EN is defined.
module tb_vga_framebuffer;

    logic        CLOCK_50 = 1'b0;
    logic        nReset;
    logic        wr_valid;
    logic        wr_ready;
    logic [13:0] wr_addr;
    logic [31:0] wr_data;
    logic        clear_req;
    logic        clear_fill;
    logic        busy;
    logic        pix_en;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic        pixel;
    logic        VGA_VS;
    logic        swap_pending;
`ifdef DOUBLE_BUFFER_EN
    logic        swap_req;
`endif

    int total = 0;
    int bad   = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    vga_framebuffer dut (
        .CLOCK_50    (CLOCK_50),
        .nReset      (nReset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clear_req   (clear_req),
        .clear_fill  (clear_fill),
        .busy        (busy),
        .pix_en      (pix_en),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel       (pixel),
        .VGA_VS      (VGA_VS),
`ifdef DOUBLE_BUFFER_EN
        .swap_req    (swap_req),
`endif
        .swap_pending(swap_pending)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic rd(input int x, input int y, input logic en,
                      output logic p);
        pixel_x = 10'(x);
        pixel_y = 9'(y);
        pix_en  = en;
        tick();
        tick();
        p = pixel;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_addr  = 14'(a);
        wr_data  = d;
        for (int n = 0; n < 20000 && !wr_ready; n++)
            tick();
        chk("wr_rdy", 32'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
    endtask

`ifdef DOUBLE_BUFFER_EN
    task automatic do_clear(input logic f);
        clear_req  = 1'b1;
        clear_fill = f;
        tick();
        clear_req  = 1'b0;
        for (int n = 0; n < 12000 && busy; n++)
            tick();
        chk("clr_done", 32'(busy), 0);
    endtask

    task automatic vs_pulse();
        VGA_VS = 1'b0;
        repeat (4) tick();
        VGA_VS = 1'b1;
        repeat (4) tick();
    endtask
`endif

    logic p;
    int   n;
    int   rdy_bad;

    initial begin
        nReset     = 1'b1;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        clear_req  = 1'b0;
        clear_fill = 1'b0;
        pix_en     = 1'b0;
        pixel_x    = '0;
        pixel_y    = '0;
        VGA_VS     = 1'b1;
`ifdef DOUBLE_BUFFER_EN
        swap_req   = 1'b0;
`endif
        #2 nReset = 1'b0;
        #3;
        chk("rst_rdy", 32'(wr_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pix", 32'(pixel), 0);
        chk("rst_swp", 32'(swap_pending), 0);
        tick();
        tick();
        nReset = 1'b1;
        chk("rel_rdy0", 32'(wr_ready), 0);
        tick();
        chk("rel_rdy1", 32'(wr_ready), 1);

`ifdef DOUBLE_BUFFER_EN
        do_clear(1'b0);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("sw1_pend", 32'(swap_pending), 1);
        vs_pulse();
        chk("sw1_done", 32'(swap_pending), 0);
        do_clear(1'b0);
        wr(0, 32'h0000_0001);
        rd(0, 0, 1'b1, p);
        chk("db_front", 32'(p), 0);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("sw2_pend", 32'(swap_pending), 1);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("sw2_again", 32'(swap_pending), 1);
        rd(0, 0, 1'b1, p);
        chk("db_hold", 32'(p), 0);
        VGA_VS = 1'b0;
        tick();
        tick();
        chk("pend_2clk", 32'(swap_pending), 1);
        tick();
        chk("pend_3clk", 32'(swap_pending), 0);
        tick();
        chk("db_pipe", 32'(pixel), 0);
        tick();
        chk("db_new", 32'(pixel), 1);
        VGA_VS = 1'b1;
`else
        wr(0, 32'h0000_0001);
        wr(1, 32'h0000_0000);
        rd(1, 0, 1'b1, p);
        chk("x1_y0", 32'(p), 0);
        pixel_x = 10'd0;
        tick();
        chk("lat1", 32'(pixel), 0);
        tick();
        chk("lat2", 32'(pixel), 1);

        wr(9599, 32'h8000_0000);
        rd(639, 479, 1'b1, p);
        chk("last", 32'(p), 1);
        rd(639, 479, 1'b0, p);
        chk("en0", 32'(p), 0);
        rd(640, 479, 1'b1, p);
        chk("x640", 32'(p), 0);
        rd(638, 479, 1'b1, p);
        chk("x638", 32'(p), 0);

        wr_valid = 1'b1;
        wr_addr  = 14'd9600;
        wr_data  = '1;
        chk("oor_rdy", 32'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
        rd(0, 0, 1'b1, p);
        chk("oor_a0b0", 32'(p), 1);
        rd(1, 0, 1'b1, p);
        chk("oor_a0b1", 32'(p), 0);

        wr_valid = 1'b1;
        wr_addr  = 14'd1;
        wr_data  = '1;
        pixel_x  = 10'd32;
        pixel_y  = 9'd0;
        pix_en   = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        chk("rbw_old", 32'(pixel), 0);
        tick();
        chk("rbw_new", 32'(pixel), 1);

        clear_req  = 1'b1;
        clear_fill = 1'b1;
        tick();
        clear_req = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 14'd5;
        wr_data   = 32'h0000_00F0;
        n       = 0;
        rdy_bad = 0;
        while (busy && n < 12000) begin
            if (wr_ready)
                rdy_bad++;
            clear_req  = (n == 100);
            clear_fill = 1'b0;
            n++;
            tick();
        end
        clear_req = 1'b0;
        chk("busy_cyc", 32'(n), 9600);
        chk("rdy_low", 32'(rdy_bad), 0);
        chk("rdy_back", 32'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
        rd(164, 0, 1'b1, p);
        chk("held_b4", 32'(p), 1);
        rd(160, 0, 1'b1, p);
        chk("held_b0", 32'(p), 0);
        rd(1, 0, 1'b1, p);
        chk("fill_1_0", 32'(p), 1);
        rd(300, 200, 1'b1, p);
        chk("fill_mid", 32'(p), 1);
        rd(100, 479, 1'b1, p);
        chk("fill_bot", 32'(p), 1);
        rd(640, 0, 1'b1, p);
        chk("fill_x640", 32'(p), 0);

        pixel_x    = 10'd639;
        pixel_y    = 9'd479;
        pix_en     = 1'b1;
        clear_req  = 1'b1;
        clear_fill = 1'b0;
        tick();
        clear_req = 1'b0;
        repeat (5000) tick();
        chk("mid_px", 32'(pixel), 1);
        chk("mid_busy", 32'(busy), 1);
        nReset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pix", 32'(pixel), 0);
        chk("abort_rdy", 32'(wr_ready), 0);
        tick();
        nReset = 1'b1;
        chk("abort_rel0", 32'(wr_ready), 0);
        tick();
        chk("abort_rel1", 32'(wr_ready), 1);
        rd(0, 0, 1'b1, p);
        chk("part_w0", 32'(p), 0);
        rd(608, 249, 1'b1, p);
        chk("part_w4999", 32'(p), 0);
        rd(32, 250, 1'b1, p);
        chk("part_w5001", 32'(p), 1);
        rd(639, 479, 1'b1, p);
        chk("part_w9599", 32'(p), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
